// File: rtl/riscv_v_elastic_stage.sv
// Valid/ready elastic buffer at the tail of the enable-driven vector stage chain.
// Holds up to DEPTH entries in order and drives stall for the upstream enables.
module riscv_v_elastic_stage #(
  parameter type DATA_T = logic,
  parameter int  DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  DATA_T                        in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output DATA_T                        out_data,
  input  logic                         out_ready,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  DATA_T              mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign stall     = in_valid && !in_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is cleared on reset only; a flush leaves stale payloads behind out_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  if (DEPTH < 2) begin : g_depth_chk
    $error("riscv_v_elastic_stage: DEPTH must be >= 2");
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $error("push while full");
      assert (!(pop && empty)) else $error("pop while empty");
      assert (count <= CNT_W'(DEPTH)) else $error("count exceeds DEPTH");
    end
  end
`endif

endmodule

// File: tb/tb_riscv_v_elastic_stage.sv
// Bench for riscv_v_elastic_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference of the buffer.
module tb_riscv_v_elastic_stage;

  localparam int DEPTH = 3;
  typedef logic [31:0] data_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  data_t       in_data;
  logic        in_ready;
  logic        out_valid;
  data_t       out_data;
  logic        out_ready;
  logic        stall;
  logic [1:0]  count;
  logic        full;
  logic        empty;

  int tests;
  int fails;

  riscv_v_elastic_stage #(.DATA_T(data_t), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall(stall), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an ordered queue holding at most DEPTH entries.
  data_t model_q[$];
  always @(posedge clk) begin
    if (rst || flush) begin
      model_q.delete();
    end else begin
      bit can_push;
      bit can_pop;
      can_push = in_valid && (model_q.size() < DEPTH);
      can_pop  = out_ready && (model_q.size() > 0);
      if (can_pop)  void'(model_q.pop_front());
      if (can_push) model_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick();
    tick();
    settle();
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_no_accept got %0d want 0", count); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + i;
      tick();
    end
    in_data = 32'hA4;
    settle();
    tests++; if (full !== 1'b1 || in_ready !== 1'b0 || stall !== 1'b1 || count !== 2'd3) begin
      fails++; $display("FAIL fill_full got full=%b in_ready=%b stall=%b count=%0d want 1/0/1/3", full, in_ready, stall, count);
    end
    tests++; if (out_data !== 32'hA1) begin fails++; $display("FAIL fill_head got %h want a1", out_data); end
    tick();
    tests++; if (count !== 2'd3 || out_data !== 32'hA1) begin
      fails++; $display("FAIL fill_hold got count=%0d data=%h want 3/a1", count, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    settle();
    tests++; if (count !== 2'd2 || in_ready !== 1'b1 || out_data !== 32'hA2) begin
      fails++; $display("FAIL fill_after_pop got count=%0d in_ready=%b data=%h want 2/1/a2", count, in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    settle();
    tests++; if (count !== 2'd3) begin fails++; $display("FAIL fill_a4_accept got %0d want 3", count); end
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      settle();
      tests++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + i) begin
        fails++; $display("FAIL fill_drain got valid=%b data=%h want 1/%h", out_valid, out_data, 32'hA0 + i);
      end
      tick();
    end
    out_ready = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fill_empty got %b want 1", empty); end
  endtask

  task automatic test_streaming();
    int errs;
    errs = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_data = k;
      settle();
      if (k == 1) begin
        if (out_valid !== 1'b0 || count !== 2'd0) errs++;
      end else if (out_valid !== 1'b1 || out_data !== k - 1 || count !== 2'd1) begin
        errs++;
        $display("FAIL stream_step%0d got valid=%b data=%0d count=%0d want 1/%0d/1", k, out_valid, out_data, count, k - 1);
      end
      tick();
    end
    in_valid = 1'b0;
    settle();
    tests++; if (out_data !== 32'd20 || out_valid !== 1'b1) begin
      fails++; $display("FAIL stream_last got valid=%b data=%0d want 1/20", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
    tests++; if (errs != 0) begin fails++; $display("FAIL stream_sequence got %0d bad steps want 0", errs); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL stream_end_count got %0d want 0", count); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'hD0 + i;
      tick();
    end
    in_data = 32'hD4; out_ready = 1'b1;
    settle();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fullpop_ready got %b want 0", in_ready); end
    tick();
    out_ready = 1'b0;
    settle();
    tests++; if (count !== 2'd2 || in_ready !== 1'b1 || out_data !== 32'hD2) begin
      fails++; $display("FAIL fullpop_next got count=%0d in_ready=%b data=%h want 2/1/d2", count, in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    tests++; if (count !== 2'd3) begin fails++; $display("FAIL fullpop_refill got %0d want 3", count); end
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      settle();
      tests++; if (out_data !== 32'hD0 + i) begin
        fails++; $display("FAIL fullpop_order got %h want %h", out_data, 32'hD0 + i);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1; tick();
    in_data = 32'hB2; tick();
    flush = 1'b1; in_data = 32'hB3; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    settle();
    tests++; if (count !== 2'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_clear got count=%0d valid=%b want 0/0", count, out_valid);
    end
    in_valid = 1'b1; in_data = 32'hC1;
    tick();
    in_valid = 1'b0;
    settle();
    tests++; if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'hC1) begin
      fails++; $display("FAIL flush_c1 got count=%0d valid=%b data=%h want 1/1/c1", count, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL flush_c1_alone got %0d want 0", count); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 1000; c++) begin
      in_valid  = $urandom_range(1, 0) == 1;
      out_ready = $urandom_range(1, 0) == 1;
      in_data   = $urandom;
      flush     = ($urandom_range(99, 0) < 3);
      settle();
      if (count !== 2'(model_q.size())) begin
        errs++; $display("FAIL rand_count cycle %0d got %0d want %0d", c, count, model_q.size());
      end
      if (out_valid !== (model_q.size() != 0)) begin
        errs++; $display("FAIL rand_valid cycle %0d got %b want %b", c, out_valid, model_q.size() != 0);
      end else if (model_q.size() != 0 && out_data !== model_q[0]) begin
        errs++; $display("FAIL rand_data cycle %0d got %h want %h", c, out_data, model_q[0]);
      end
      if (in_ready !== (model_q.size() < DEPTH) || stall !== (in_valid && model_q.size() >= DEPTH)) begin
        errs++; $display("FAIL rand_ready cycle %0d got in_ready=%b stall=%b", c, in_ready, stall);
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (errs != 0) begin fails++; $display("FAIL rand_total got %0d errors want 0", errs); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_fill();
    test_streaming();
    test_full_pop();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
